// File: rtl/md_ctrl_pkg.sv
// Shared mult/div unit definitions: md_op_* encodings and the FSM state type.
package md_ctrl_pkg;

    localparam logic [2:0] md_op_mult  = 3'd0;
    localparam logic [2:0] md_op_multu = 3'd1;
    localparam logic [2:0] md_op_div   = 3'd2;
    localparam logic [2:0] md_op_divu  = 3'd3;
    localparam logic [2:0] md_op_mthi  = 3'd4;
    localparam logic [2:0] md_op_mtlo  = 3'd5;
    localparam logic [2:0] md_op_madd  = 3'd6;
    localparam logic [2:0] md_op_maddu = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_ctrl_alu.sv
// md_alu: combinational 64-bit product (optionally accumulated) and quotient/remainder.
// Accumulation for madd/maddu is compiled in only with MD_MADD_EN.
module md_alu
    import md_ctrl_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] mul_o,
    output logic [63:0] div_o,
    output logic        div_zero_o
);

    logic               sgn;
    logic               acc;
    logic [63:0]        a64, b64, prod;
    logic signed [63:0] dvd, dvs, quo, rem;
    logic               unused_upper;

    always_comb begin
        sgn = (op_i == md_op_mult) || (op_i == md_op_div) || (op_i == md_op_madd);
`ifdef MD_MADD_EN
        acc = (op_i == md_op_madd) || (op_i == md_op_maddu);
`else
        acc = 1'b0;
`endif
        a64  = sgn ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
        b64  = sgn ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
        // Low 64 bits of the extended product are correct for both signednesses.
        prod  = a64 * b64;
        mul_o = prod + (acc ? {hi_i, lo_i} : 64'd0);

        // 64-bit signed divide covers divu (zero-extended) and the -2^31/-1 case.
        div_zero_o = (b_i == 32'd0);
        dvd = $signed(a64);
        dvs = div_zero_o ? 64'sd1 : $signed(b64);
        quo = dvd / dvs;
        rem = dvd % dvs;
        div_o = {rem[31:0], quo[31:0]};
    end

    assign unused_upper = ^{quo[63:32], rem[63:32]};

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle mult/div controller holding HI/LO, FSM, busy counter and result latch.
// Define MD_MADD_EN to enable madd/maddu accumulation.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 2);

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic        we_q, we_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [63:0] mul_res, div_res;
    logic        div_zero;
    logic        is_mul, is_div;

    md_alu u_alu (
        .op_i      (Op),
        .a_i       (A),
        .b_i       (B),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .mul_o     (mul_res),
        .div_o     (div_res),
        .div_zero_o(div_zero)
    );

`ifdef MD_MADD_EN
    assign is_mul = (Op == md_op_mult) || (Op == md_op_multu) ||
                    (Op == md_op_madd) || (Op == md_op_maddu);
`else
    assign is_mul = (Op == md_op_mult) || (Op == md_op_multu);
`endif
    assign is_div = (Op == md_op_div) || (Op == md_op_divu);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        we_d    = we_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start && !Cancel) begin
                    if (is_mul) begin
                        state_d = ST_MUL_RUN;
                        cnt_d   = CW'(MULT_CYCLES);
                        res_d   = mul_res;
                        we_d    = 1'b1;
                    end else if (is_div) begin
                        state_d = ST_DIV_RUN;
                        cnt_d   = CW'(DIV_CYCLES);
                        res_d   = div_res;
                        we_d    = !div_zero;
                    end else if (Op == md_op_mthi) begin
                        hi_d = A;
                    end else if (Op == md_op_mtlo) begin
                        lo_d = A;
                    end
                end
            end
            default: begin
                // Start is ignored here; the hazard unit stalls the pipe while Busy.
                if (Cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    res_d   = '0;
                    we_d    = 1'b0;
                end else if (cnt_q <= CW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    res_d   = '0;
                    we_d    = 1'b0;
                    if (we_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            we_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            we_q    <= we_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q != ST_IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed vector table, hand sequences, random vs model.
module tb_md_ctrl;
    import md_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Start = 1'b0;
    logic        Cancel = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .Cancel(Cancel), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: result of an accepted op, straight from the arithmetic definitions.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
        longint x, y, q, r;
        logic [63:0] p;
        p = {hi, lo};
        case (op)
            md_op_mult:  p = 64'(longint'($signed(a)) * longint'($signed(b)));
            md_op_multu: p = {32'd0, a} * {32'd0, b};
`ifdef MD_MADD_EN
            md_op_madd:  p = {hi, lo} + 64'(longint'($signed(a)) * longint'($signed(b)));
            md_op_maddu: p = {hi, lo} + {32'd0, a} * {32'd0, b};
`endif
            md_op_div, md_op_divu: begin
                x = (op == md_op_div) ? longint'($signed(a)) : longint'({32'd0, a});
                y = (op == md_op_div) ? longint'($signed(b)) : longint'({32'd0, b});
                if (y != 0) begin
                    q = x / y;
                    r = x - q * y;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = {hi, lo};
        endcase
        return p;
    endfunction

    function automatic bit ref_is_mul(input logic [2:0] op);
`ifdef MD_MADD_EN
        return op == md_op_mult || op == md_op_multu || op == md_op_madd || op == md_op_maddu;
`else
        return op == md_op_mult || op == md_op_multu;
`endif
    endfunction

    // Model timeline: busy while cycle index < m_end; result lands when the index reaches m_end.
    int          m_cyc = 0;
    int          m_end = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [63:0] m_p = 64'd0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
            m_end <= m_cyc;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc < m_end) begin
                if (Cancel) m_end <= m_cyc + 1;
                else if (m_cyc + 1 == m_end) {m_hi, m_lo} <= m_p;
            end else if (Start && !Cancel) begin
                if (ref_is_mul(Op)) begin
                    m_p   <= ref_op(Op, A, B, m_hi, m_lo);
                    m_end <= m_cyc + 1 + MC;
                end else if (Op == md_op_div || Op == md_op_divu) begin
                    m_p   <= ref_op(Op, A, B, m_hi, m_lo);
                    m_end <= m_cyc + 1 + DC;
                end else if (Op == md_op_mthi) begin
                    m_hi <= A;
                end else if (Op == md_op_mtlo) begin
                    m_lo <= A;
                end
            end
        end
    end

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [31:0] hi, lo;
        int          cyc;
    } vec_t;

    vec_t vt[12];

    logic [31:0] e_hi = 32'd0, e_lo = 32'd0;

    task automatic run_vec(input vec_t v);
        int n;
        Start = 1'b1; Op = v.op; A = v.a; B = v.b;
        tick();
        Start = 1'b0;
        n = 0;
        while (Busy && n < 60) begin
            check({v.name, "_hold_hi"}, HI, e_hi);
            check({v.name, "_hold_lo"}, LO, e_lo);
            n++;
            tick();
        end
        check({v.name, "_cycles"}, n, v.cyc);
        check({v.name, "_hi"}, HI, v.hi);
        check({v.name, "_lo"}, LO, v.lo);
        e_hi = v.hi;
        e_lo = v.lo;
    endtask

    initial begin
        int n;
        vt[0]  = '{"mthi",      md_op_mthi,  32'h11111111, 32'h0,        32'h11111111, 32'h00000000, 0};
        vt[1]  = '{"mtlo",      md_op_mtlo,  32'h22222222, 32'h0,        32'h11111111, 32'h22222222, 0};
        vt[2]  = '{"mult",      md_op_mult,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, MC};
        vt[3]  = '{"multu",     md_op_multu, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MC};
        vt[4]  = '{"div_neg",   md_op_div,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vt[5]  = '{"divu_zero", md_op_divu,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vt[6]  = '{"divu",      md_op_divu,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DC};
        vt[7]  = '{"div_negb",  md_op_div,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
        vt[8]  = '{"mthi0",     md_op_mthi,  32'h00000000, 32'h0,        32'h00000000, 32'hFFFFFFFD, 0};
        vt[9]  = '{"mtlo1s",    md_op_mtlo,  32'hFFFFFFFF, 32'h0,        32'h00000000, 32'hFFFFFFFF, 0};
`ifdef MD_MADD_EN
        vt[10] = '{"maddu",     md_op_maddu, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, MC};
`else
        vt[10] = '{"maddu_off", md_op_maddu, 32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 0};
`endif
        vt[11] = '{"mult_neg",  md_op_mult,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, MC};

        // Reset state
        #2 Reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        tick(); tick();
        Reset_n = 1'b1;
        tick();

        foreach (vt[i]) run_vec(vt[i]);

        // Cancel in the third busy cycle of a mult
        Start = 1'b1; Op = md_op_mult; A = 32'd3; B = 32'd3;
        tick();
        Start = 1'b0;
        check("cxl_busy1", 32'(Busy), 32'd1);
        tick();
        tick();
        check("cxl_busy3", 32'(Busy), 32'd1);
        Cancel = 1'b1;
        tick();
        Cancel = 1'b0;
        check("cxl_busy_off", 32'(Busy), 32'd0);
        repeat (6) tick();
        check("cxl_idle", 32'(Busy), 32'd0);
        check("cxl_hi", HI, 32'hFFFFFFFF);
        check("cxl_lo", LO, 32'hFFFFFFEB);

        // mtlo discarded by same-cycle Cancel
        Start = 1'b1; Op = md_op_mtlo; A = 32'h12345678; Cancel = 1'b1;
        tick();
        Start = 1'b0; Cancel = 1'b0;
        check("mtlo_cxl_lo", LO, 32'hFFFFFFEB);
        check("mtlo_cxl_busy", 32'(Busy), 32'd0);

        // Start held during Busy is ignored
        Start = 1'b1; Op = md_op_mult; A = 32'd2; B = 32'd3;
        tick();
        Op = md_op_div; A = 32'd100; B = 32'd7;
        n = 0;
        while (Busy && n < 60) begin
            n++;
            if (n == 3) Start = 1'b0;
            tick();
        end
        Start = 1'b0;
        check("b2b_cycles", n, MC);
        check("b2b_hi", HI, 32'd0);
        check("b2b_lo", LO, 32'd6);
        repeat (12) tick();
        check("b2b_noqueue_busy", 32'(Busy), 32'd0);
        check("b2b_noqueue_lo", LO, 32'd6);

        // Reset in the fourth cycle of a div
        Start = 1'b1; Op = md_op_div; A = 32'd100; B = 32'd7;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        Reset_n = 1'b0;
        #1;
        check("mrst_busy", 32'(Busy), 32'd0);
        check("mrst_hi", HI, 32'd0);
        check("mrst_lo", LO, 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        Start = 1'b1; Op = md_op_mult; A = 32'd2; B = 32'd3;
        tick();
        Start = 1'b0;
        n = 0;
        while (Busy && n < 60) begin n++; tick(); end
        check("post_rst_cycles", n, MC);
        check("post_rst_lo", LO, 32'd6);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            Start  = ($urandom_range(2) == 0);
            Op     = 3'($urandom_range(7));
            A      = ($urandom_range(9) == 0) ? 32'h80000000 : $urandom;
            B      = ($urandom_range(7) == 0) ? 32'd0 :
                     ($urandom_range(9) == 0) ? 32'hFFFFFFFF : $urandom;
            Cancel = ($urandom_range(19) == 0);
            tick();
            check("rnd_busy", 32'(Busy), 32'(m_cyc < m_end));
            check("rnd_hi", HI, m_hi);
            check("rnd_lo", LO, m_lo);
        end
        Start = 1'b0; Cancel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
